// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between I-cache
// refills and D-cache refills/writebacks; one transaction in flight at a time.
module l1_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [LINE_W-1:0] i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [LINE_W-1:0] d_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  logic              r_ownerD;
  logic              r_prioD;
  logic              r_busy;
  logic              r_protoErr;
  logic              r_memReqValid;
  logic [ADDR_W-1:0] r_memReqAddr;
  logic              r_memReqWe;
  logic [LINE_W-1:0] r_memReqWdata;
  logic              r_iRspValid;
  logic [LINE_W-1:0] r_iRspData;
  logic              r_dRspValid;
  logic [LINE_W-1:0] r_dRspData;

  logic w_idle;
  logic w_grantI;
  logic w_grantD;

  // Grants are only offered in IDLE and out of reset; r_prioD breaks ties.
  assign w_idle   = rst && (r_state == IDLE);
  assign w_grantD = w_idle && d_req_valid && (!i_req_valid || r_prioD);
  assign w_grantI = w_idle && i_req_valid && (!d_req_valid || !r_prioD);

  assign i_req_ready   = w_grantI;
  assign d_req_ready   = w_grantD;
  assign i_rsp_valid   = r_iRspValid;
  assign i_rsp_data    = r_iRspData;
  assign d_rsp_valid   = r_dRspValid;
  assign d_rsp_data    = r_dRspData;
  assign mem_req_valid = r_memReqValid;
  assign mem_req_addr  = r_memReqAddr;
  assign mem_req_we    = r_memReqWe;
  assign mem_req_wdata = r_memReqWdata;
  assign busy          = r_busy;
  assign proto_err     = r_protoErr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_ownerD      <= 1'b0;
      r_prioD       <= 1'b1;
      r_busy        <= 1'b0;
      r_protoErr    <= 1'b0;
      r_memReqValid <= 1'b0;
      r_memReqAddr  <= '0;
      r_memReqWe    <= 1'b0;
      r_memReqWdata <= '0;
      r_iRspValid   <= 1'b0;
      r_iRspData    <= '0;
      r_dRspValid   <= 1'b0;
      r_dRspData    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_rsp_valid) r_protoErr <= 1'b1;
          if (w_grantI || w_grantD) begin
            r_state       <= ISSUE;
            r_busy        <= 1'b1;
            r_memReqValid <= 1'b1;
            r_ownerD      <= w_grantD;
            r_prioD       <= w_grantI;
            r_memReqAddr  <= w_grantD ? d_req_addr : i_req_addr;
            r_memReqWe    <= w_grantD && d_req_we;
            r_memReqWdata <= w_grantD ? d_req_wdata : '0;
          end
        end
        ISSUE: begin
          // A response before the request handshake completes is illegal.
          if (mem_rsp_valid) r_protoErr <= 1'b1;
          if (mem_req_ready) begin
            r_memReqValid <= 1'b0;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (r_ownerD) begin
              r_dRspData  <= mem_rsp_data;
              r_dRspValid <= 1'b1;
            end else begin
              r_iRspData  <= mem_rsp_data;
              r_iRspValid <= 1'b1;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          if (mem_rsp_valid) r_protoErr <= 1'b1;
          r_iRspValid <= 1'b0;
          r_dRspValid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level round-robin model.
module tb_l1_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [LINE_W-1:0] wdata;
  } req_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_req_valid = 1'b0;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr = '0;
  logic              i_rsp_valid;
  logic [LINE_W-1:0] i_rsp_data;
  logic              d_req_valid = 1'b0;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr = '0;
  logic              d_req_we = 1'b0;
  logic [LINE_W-1:0] d_req_wdata = '0;
  logic              d_rsp_valid;
  logic [LINE_W-1:0] d_rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid = 1'b0;
  logic [LINE_W-1:0] mem_rsp_data = '0;
  logic              busy;
  logic              proto_err;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .proto_err(proto_err)
  );

  int nCompared = 0;
  int nMismatched = 0;

  // Client request queues and observation logs
  logic [ADDR_W-1:0] iQ[$];
  req_t              dQ[$];
  req_t              memLog[$];
  bit                grantLog[$];
  int                grantCyc[$];
  int                memStartCyc[$];
  int                holdLog[$];
  logic [LINE_W-1:0] rspILog[$];
  int                rspICyc[$];
  logic [LINE_W-1:0] rspDLog[$];
  int                rspDCyc[$];
  int cyc = 0;
  int readyBusyViol = 0;
  int stableViol = 0;

  // Memory model state
  int  readyDelay = 0;
  int  respDelay = 0;
  bit  randDelays = 0;
  bit  useFixed = 0;
  bit  inject = 0;
  logic [LINE_W-1:0] fixedData = '0;
  int  waitCnt = 0;
  int  rspCnt = 0;
  bit  rspPending = 0;
  logic [ADDR_W-1:0] pendAddr = '0;
  bit  prevMemValid = 0;
  req_t prevReq;
  int  curHold = 0;

  function automatic logic [LINE_W-1:0] lineFor(logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0123_4567};
  endfunction

  task automatic clearLogs();
    memLog.delete(); grantLog.delete(); grantCyc.delete(); memStartCyc.delete();
    holdLog.delete(); rspILog.delete(); rspICyc.delete(); rspDLog.delete(); rspDCyc.delete();
    readyBusyViol = 0; stableViol = 0;
  endtask

  task automatic clearMem();
    rspPending = 0; waitCnt = readyDelay; rspCnt = 0; curHold = 0; prevMemValid = 0;
  endtask

  // One clock cycle: observe at negedge, drive clients and memory, commit at posedge.
  task automatic step();
    bit iGrant, dGrant;
    @(negedge clk);
    if (i_rsp_valid === 1'b1) begin rspILog.push_back(i_rsp_data); rspICyc.push_back(cyc); end
    if (d_rsp_valid === 1'b1) begin rspDLog.push_back(d_rsp_data); rspDCyc.push_back(cyc); end
    if (mem_req_valid === 1'b1) begin
      if (prevMemValid) begin
        if (mem_req_addr !== prevReq.addr || mem_req_we !== prevReq.we ||
            mem_req_wdata !== prevReq.wdata) stableViol++;
      end else memStartCyc.push_back(cyc);
      curHold++;
    end
    prevMemValid = (mem_req_valid === 1'b1);
    prevReq.addr = mem_req_addr; prevReq.we = mem_req_we; prevReq.wdata = mem_req_wdata;

    i_req_valid = (iQ.size() > 0);
    i_req_addr  = (iQ.size() > 0) ? iQ[0] : '0;
    d_req_valid = (dQ.size() > 0);
    d_req_addr  = (dQ.size() > 0) ? dQ[0].addr : '0;
    d_req_we    = (dQ.size() > 0) ? dQ[0].we : 1'b0;
    d_req_wdata = (dQ.size() > 0) ? dQ[0].wdata : '0;

    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if (rspPending) begin
      if (rspCnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = useFixed ? fixedData : lineFor(pendAddr);
        rspPending = 0;
      end else rspCnt--;
    end else if (mem_req_valid === 1'b1) begin
      if (waitCnt == 0) begin
        mem_req_ready = 1'b1;
        pendAddr = mem_req_addr;
        memLog.push_back(prevReq);
        holdLog.push_back(curHold);
        curHold = 0;
        rspPending = 1;
        rspCnt  = randDelays ? int'($urandom_range(0, 3)) : respDelay;
        waitCnt = randDelays ? int'($urandom_range(0, 3)) : readyDelay;
      end else waitCnt--;
    end
    if (inject) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = lineFor(32'hDEAD_0000);
    end

    #1;
    iGrant = (i_req_ready === 1'b1);
    dGrant = (d_req_ready === 1'b1);
    if ((iGrant || dGrant) && busy === 1'b1) readyBusyViol++;
    if (iGrant) begin grantLog.push_back(1'b0); grantCyc.push_back(cyc); end
    if (dGrant) begin grantLog.push_back(1'b1); grantCyc.push_back(cyc); end
    @(posedge clk);
    if (iGrant) void'(iQ.pop_front());
    if (dGrant) void'(dQ.pop_front());
    cyc++;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    iQ.delete(); dQ.delete();
    inject = 0; useFixed = 0; randDelays = 0; readyDelay = 0; respDelay = 0;
    clearMem();
    step(); step();
    rst = 1'b1;
    clearLogs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    iQ.push_back(32'h10);
    dQ.push_back('{addr: 32'h20, we: 1'b0, wdata: '0});
    step(); step();
    nCompared++;
    if (grantLog.size() !== 0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ready: %0d grants during reset, expected 0", grantLog.size());
    end
    nCompared++;
    if ({mem_req_valid, busy, proto_err, i_rsp_valid, d_rsp_valid} !== 5'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {mem_req_valid, busy, proto_err, i_rsp_valid, d_rsp_valid});
    end
    nCompared++;
    if ({mem_req_addr, mem_req_we, mem_req_wdata} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_memreq: addr %h we %b wdata %h expected zeros",
               mem_req_addr, mem_req_we, mem_req_wdata);
    end
    nCompared++;
    if ({i_rsp_data, d_rsp_data} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_rspdata: i %h d %h expected zeros", i_rsp_data, d_rsp_data);
    end
    iQ.delete(); dQ.delete();
    step();
    rst = 1'b1;
    step();
    nCompared++;
    if (busy !== 1'b0 || grantLog.size() !== 0) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle: busy %b grants %0d expected 0/0", busy, grantLog.size());
    end
  endtask

  task automatic test_i_read();
    doReset();
    useFixed = 1;
    fixedData = {8{16'hAAAA}};
    iQ.push_back(32'h100);
    for (int k = 0; k < 20 && rspILog.size() < 1; k++) step();
    for (int k = 0; k < 3; k++) step();
    nCompared++;
    if (grantLog.size() !== 1 || rspILog.size() !== 1 || memLog.size() !== 1) begin
      nMismatched++;
      $display("[TB] FAIL iread_counts: grants %0d rsps %0d memreqs %0d expected 1/1/1",
               grantLog.size(), rspILog.size(), memLog.size());
    end else begin
      nCompared++;
      if (grantLog[0] !== 1'b0) begin
        nMismatched++; $display("[TB] FAIL iread_owner: got D expected I");
      end
      nCompared++;
      if (memLog[0].addr !== 32'h100 || memLog[0].we !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL iread_memreq: addr %h we %b expected 00000100/0", memLog[0].addr, memLog[0].we);
      end
      nCompared++;
      if (memStartCyc[0] - grantCyc[0] !== 1) begin
        nMismatched++;
        $display("[TB] FAIL iread_issue_lat: %0d expected 1", memStartCyc[0] - grantCyc[0]);
      end
      nCompared++;
      if (rspICyc[0] - grantCyc[0] !== 3) begin
        nMismatched++;
        $display("[TB] FAIL iread_rsp_lat: %0d expected 3", rspICyc[0] - grantCyc[0]);
      end
      nCompared++;
      if (rspILog[0] !== fixedData) begin
        nMismatched++;
        $display("[TB] FAIL iread_data: got %h expected %h", rspILog[0], fixedData);
      end
    end
    nCompared++;
    if (rspDLog.size() !== 0) begin
      nMismatched++; $display("[TB] FAIL iread_no_d: %0d D pulses expected 0", rspDLog.size());
    end
    useFixed = 0;
  endtask

  task automatic test_both();
    doReset();
    iQ.push_back(32'h200);
    dQ.push_back('{addr: 32'h300, we: 1'b0, wdata: '0});
    for (int k = 0; k < 40 && (rspILog.size() < 1 || rspDLog.size() < 1); k++) step();
    for (int k = 0; k < 3; k++) step();
    nCompared++;
    if (memLog.size() !== 2 || rspILog.size() !== 1 || rspDLog.size() !== 1) begin
      nMismatched++;
      $display("[TB] FAIL both_counts: memreqs %0d irsp %0d drsp %0d expected 2/1/1",
               memLog.size(), rspILog.size(), rspDLog.size());
    end else begin
      nCompared++;
      if (memLog[0].addr !== 32'h300 || memLog[1].addr !== 32'h200) begin
        nMismatched++;
        $display("[TB] FAIL both_order: got %h,%h expected 00000300,00000200", memLog[0].addr, memLog[1].addr);
      end
      nCompared++;
      if (rspDLog[0] !== lineFor(32'h300) || rspILog[0] !== lineFor(32'h200)) begin
        nMismatched++;
        $display("[TB] FAIL both_data: d %h i %h expected d %h i %h",
                 rspDLog[0], rspILog[0], lineFor(32'h300), lineFor(32'h200));
      end
    end
  endtask

  task automatic test_writeback();
    doReset();
    readyDelay = 3;
    waitCnt = 3;
    dQ.push_back('{addr: 32'h40, we: 1'b1, wdata: 128'h1234});
    for (int k = 0; k < 30 && rspDLog.size() < 1; k++) step();
    for (int k = 0; k < 3; k++) step();
    nCompared++;
    if (memLog.size() !== 1 || rspDLog.size() !== 1 || rspILog.size() !== 0) begin
      nMismatched++;
      $display("[TB] FAIL wb_counts: memreqs %0d drsp %0d irsp %0d expected 1/1/0",
               memLog.size(), rspDLog.size(), rspILog.size());
    end else begin
      nCompared++;
      if (holdLog[0] !== 4) begin
        nMismatched++; $display("[TB] FAIL wb_hold: valid held %0d cycles expected 4", holdLog[0]);
      end
      nCompared++;
      if (memLog[0].addr !== 32'h40 || memLog[0].we !== 1'b1 || memLog[0].wdata !== 128'h1234) begin
        nMismatched++;
        $display("[TB] FAIL wb_fields: addr %h we %b wdata %h expected 00000040/1/1234",
                 memLog[0].addr, memLog[0].we, memLog[0].wdata);
      end
    end
    nCompared++;
    if (stableViol !== 0) begin
      nMismatched++; $display("[TB] FAIL wb_stable: %0d changes while waiting expected 0", stableViol);
    end
    readyDelay = 0;
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int k = 0; k < 3; k++) begin
      iQ.push_back($urandom & 32'hFFFF_FFF0);
      dQ.push_back('{addr: $urandom & 32'hFFFF_FFF0, we: 1'($urandom_range(0, 1)),
                     wdata: {$urandom, $urandom, $urandom, $urandom}});
    end
    for (int k = 0; k < 100 && (rspILog.size() + rspDLog.size()) < 6; k++) step();
    for (int k = 0; k < 3; k++) step();
    nCompared++;
    if (grantLog.size() !== 6) begin
      nMismatched++; $display("[TB] FAIL b2b_count: %0d grants expected 6", grantLog.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        nCompared++;
        if (grantLog[k] !== ((k % 2) == 0)) begin
          nMismatched++;
          $display("[TB] FAIL b2b_alternate[%0d]: got D=%0b expected D=%0b", k, grantLog[k], (k % 2) == 0);
        end
      end
      for (int k = 1; k < 6; k++) begin
        nCompared++;
        if (grantCyc[k] - grantCyc[k-1] !== 4) begin
          nMismatched++;
          $display("[TB] FAIL b2b_gap[%0d]: %0d cycles expected 4", k, grantCyc[k] - grantCyc[k-1]);
        end
      end
    end
    nCompared++;
    if (readyBusyViol !== 0) begin
      nMismatched++; $display("[TB] FAIL b2b_ready_busy: %0d cycles expected 0", readyBusyViol);
    end
  endtask

  task automatic test_proto_err();
    doReset();
    inject = 1;
    step();
    inject = 0;
    nCompared++;
    if (proto_err !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL proto_set: got %b expected 1", proto_err);
    end
    for (int k = 0; k < 4; k++) step();
    nCompared++;
    if (proto_err !== 1'b1 || rspILog.size() !== 0 || rspDLog.size() !== 0) begin
      nMismatched++;
      $display("[TB] FAIL proto_sticky: err %b irsp %0d drsp %0d expected 1/0/0",
               proto_err, rspILog.size(), rspDLog.size());
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    nCompared++;
    if (proto_err !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL proto_clear: got %b expected 0", proto_err);
    end
  endtask

  task automatic test_reset_in_wait();
    doReset();
    respDelay = 6;
    iQ.push_back(32'h500);
    for (int k = 0; k < 20 && memLog.size() < 1; k++) step();
    step();
    nCompared++;
    if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rstwait_reach: busy %b memvalid %b expected 1/0", busy, mem_req_valid);
    end
    rst = 1'b0;
    step();
    nCompared++;
    if ({busy, mem_req_valid, i_rsp_valid, d_rsp_valid, mem_req_we} !== 5'b0 ||
        mem_req_addr !== '0 || i_rsp_data !== '0) begin
      nMismatched++;
      $display("[TB] FAIL rstwait_clear: flags %b addr %h idata %h expected zeros",
               {busy, mem_req_valid, i_rsp_valid, d_rsp_valid, mem_req_we}, mem_req_addr, i_rsp_data);
    end
    rst = 1'b1;
    for (int k = 0; k < 10; k++) step();
    nCompared++;
    if (rspILog.size() !== 0 || rspDLog.size() !== 0) begin
      nMismatched++;
      $display("[TB] FAIL rstwait_late: irsp %0d drsp %0d expected 0/0", rspILog.size(), rspDLog.size());
    end
    respDelay = 0;
  endtask

  // Transaction-level model: both queues prefilled, so every decision sees
  // all remaining clients valid and the pointer alternates between winners.
  task automatic test_random();
    logic [ADDR_W-1:0] iReq[$];
    req_t dReq[$];
    req_t expLog[$];
    logic [LINE_W-1:0] expI[$];
    logic [LINE_W-1:0] expD[$];
    int nI, nD, ii, dd, total;
    bit ptrD;
    doReset();
    randDelays = 1;
    nI = $urandom_range(3, 8);
    nD = $urandom_range(3, 8);
    for (int k = 0; k < nI; k++) iReq.push_back($urandom);
    for (int k = 0; k < nD; k++)
      dReq.push_back('{addr: $urandom, we: 1'($urandom_range(0, 1)),
                       wdata: {$urandom, $urandom, $urandom, $urandom}});
    ptrD = 1; ii = 0; dd = 0;
    while (ii < nI || dd < nD) begin
      if ((ii < nI && dd < nD) ? ptrD : (dd < nD)) begin
        expLog.push_back(dReq[dd]); expD.push_back(lineFor(dReq[dd].addr)); dd++; ptrD = 0;
      end else begin
        expLog.push_back('{addr: iReq[ii], we: 1'b0, wdata: '0});
        expI.push_back(lineFor(iReq[ii])); ii++; ptrD = 1;
      end
    end
    foreach (iReq[k]) iQ.push_back(iReq[k]);
    foreach (dReq[k]) dQ.push_back(dReq[k]);
    total = nI + nD;
    for (int k = 0; k < 3000 && (rspILog.size() + rspDLog.size()) < total; k++) step();
    for (int k = 0; k < 3; k++) step();
    nCompared++;
    if (memLog.size() !== total || rspILog.size() !== nI || rspDLog.size() !== nD) begin
      nMismatched++;
      $display("[TB] FAIL rand_counts: memreqs %0d irsp %0d drsp %0d expected %0d/%0d/%0d",
               memLog.size(), rspILog.size(), rspDLog.size(), total, nI, nD);
    end else begin
      for (int k = 0; k < total; k++) begin
        nCompared++;
        if (memLog[k].addr !== expLog[k].addr || memLog[k].we !== expLog[k].we ||
            memLog[k].wdata !== expLog[k].wdata) begin
          nMismatched++;
          $display("[TB] FAIL rand_memreq[%0d]: got %h/%b/%h expected %h/%b/%h", k,
                   memLog[k].addr, memLog[k].we, memLog[k].wdata,
                   expLog[k].addr, expLog[k].we, expLog[k].wdata);
        end
      end
      for (int k = 0; k < nI; k++) begin
        nCompared++;
        if (rspILog[k] !== expI[k]) begin
          nMismatched++; $display("[TB] FAIL rand_irsp[%0d]: got %h expected %h", k, rspILog[k], expI[k]);
        end
      end
      for (int k = 0; k < nD; k++) begin
        nCompared++;
        if (rspDLog[k] !== expD[k]) begin
          nMismatched++; $display("[TB] FAIL rand_drsp[%0d]: got %h expected %h", k, rspDLog[k], expD[k]);
        end
      end
    end
    nCompared++;
    if (readyBusyViol !== 0 || stableViol !== 0 || proto_err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rand_rules: ready/busy %0d unstable %0d proto_err %b expected 0/0/0",
               readyBusyViol, stableViol, proto_err);
    end
    randDelays = 0;
  endtask

  initial begin
    $display("[TB] starting l1_mem_arbiter bench");
    test_reset();
    test_i_read();
    test_both();
    test_writeback();
    test_back_to_back();
    test_proto_err();
    test_reset_in_wait();
    for (int r = 0; r < 3; r++) test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
